self_link_fifo_buffer_p: RTL and testbench



---
 rtl/self_link_pkg.sv | 27 ++
 rtl/self_link_fifo_buffer_p_if.sv | 12 +
 rtl/self_link_fifo_ram.sv | 47 ++++
 rtl/self_link_fifo_buffer_p.sv | 111 +++++++++++
 tb/tb_self_link_fifo_buffer_p.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/self_link_pkg.sv
// Shared helpers for the parametrised SELF link FIFO buffer.
// Latency: none (package only).
// Backpressure: n/a; provides the SELF transfer rule and parameter sanity checks.
package self_link_pkg;

  // A SELF word moves when the sender has it valid and the receiver is not stopping.
  function automatic logic self_xfer(input logic vld, input logic stop);
    return vld & ~stop;
  endfunction

  function automatic int self_link_clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res = res + 1;
    return res;
  endfunction

  // Depth must be a power of two >= 2, the index width must match it,
  // and the stop watermark must lie within the array.
  function automatic bit self_link_params_ok(input int fifo_size, input int index_size,
                                             input int stop_level);
    return (fifo_size >= 2) && ((fifo_size & (fifo_size - 1)) == 0) &&
           (index_size == self_link_clog2(fifo_size)) &&
           (stop_level >= 1) && (stop_level <= fifo_size);
  endfunction

endpackage

// File: rtl/self_link_fifo_buffer_p_if.sv
// One SELF link (valid/data forward, stop backward) between a producer and a consumer.
// Latency: none (wires only).
// Backpressure: stop driven by the receiver; the word moves when valid & !stop.
// Ports: valid, data[DataWidth], stop. master = producer side, slave = consumer side.
interface self_link_fifo_buffer_p_if #(parameter int DataWidth = 8);
  logic                 valid;
  logic [DataWidth-1:0] data;
  logic                 stop;

  modport master (output valid, output data, input stop);
  modport slave  (input valid, input data, output stop);
endinterface

// File: rtl/self_link_fifo_ram.sv
// Simple dual-port storage array for the SELF link FIFO buffer.
// Latency: head word is valid the cycle after its read address is presented (either mode).
// Backpressure: none; the owner guarantees no overflow.
// Ports: clk, srst, i_wr_en/i_wr_addr/i_wr_dat write port, i_rd_addr_nxt next head
// address, o_rd_dat head word.
module self_link_fifo_ram #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 4
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 i_wr_en,
  input  logic [AddrWidth-1:0] i_wr_addr,
  input  logic [DataWidth-1:0] i_wr_dat,
  input  logic [AddrWidth-1:0] i_rd_addr_nxt,
  output logic [DataWidth-1:0] o_rd_dat
);
  // 0: registered address + asynchronous array read; 1: registered data read.
  localparam bit ReadReg = 1'b0;
  localparam int Depth   = 1 << AddrWidth;

  logic [DataWidth-1:0] r_mem [Depth];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
  end

  generate
    if (ReadReg) begin : g_rd_reg
      logic [DataWidth-1:0] r_rd_dat;
      // Forward a same-cycle write into the next head slot (empty FIFO being filled).
      always_ff @(posedge clk) begin
        if (srst) r_rd_dat <= '0;
        else if (i_wr_en && (i_wr_addr == i_rd_addr_nxt)) r_rd_dat <= i_wr_dat;
        else r_rd_dat <= r_mem[i_rd_addr_nxt];
      end
      assign o_rd_dat = r_rd_dat;
    end else begin : g_rd_async
      logic [AddrWidth-1:0] r_rd_addr;
      always_ff @(posedge clk) begin
        if (srst) r_rd_addr <= '0;
        else r_rd_addr <= i_rd_addr_nxt;
      end
      assign o_rd_dat = r_mem[r_rd_addr];
    end
  endgenerate
endmodule

// File: rtl/self_link_fifo_buffer_p.sv
// Elastic SELF link buffer: storage array + registered output stage with empty bypass.
// Latency: 1 cycle when empty (bypass), otherwise count+1 cycles behind the queue.
// Backpressure: registered stop asserts once next array occupancy >= StopLevel.
// Ports: clk, srst (sync, active-high); in_link (slave: dataInValid/dataIn/dataInStop);
// out_link (master: dataOutValid/dataOut/dataOutStop).
// Optional macro SELF_LINK_FIFO_LEVEL_EN adds fillLevel (array + output reg) and sticky overflowErr.
module self_link_fifo_buffer_p
  import self_link_pkg::*;
#(
  parameter int DataWidth     = 8,
  parameter int FifoSize      = 16,
  parameter int FifoIndexSize = 4,
  parameter int StopLevel     = 16
) (
  input  logic                            clk,
  input  logic                            srst,
  self_link_fifo_buffer_p_if.slave        in_link,
  self_link_fifo_buffer_p_if.master       out_link
`ifdef SELF_LINK_FIFO_LEVEL_EN
  ,
  output logic [FifoIndexSize+1:0]        fillLevel,
  output logic                            overflowErr
`endif
);
  generate
    if (!self_link_params_ok(FifoSize, FifoIndexSize, StopLevel)) begin : g_bad_params
      $error("self_link_fifo_buffer_p: illegal FifoSize/FifoIndexSize/StopLevel");
    end
  endgenerate

  localparam logic [FifoIndexSize-1:0] PtrOne  = 1;
  localparam logic [FifoIndexSize:0]   CntOne  = 1;
  localparam logic [FifoIndexSize:0]   StopLvl = (FifoIndexSize+1)'(StopLevel);

  logic [FifoIndexSize-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [FifoIndexSize:0]   r_count, w_count_nxt;
  logic                     r_stop, r_out_vld;
  logic [DataWidth-1:0]     r_out_dat, w_head_dat;
  logic                     w_push, w_load, w_has_data, w_arr_rd, w_bypass, w_arr_wr;
  logic                     w_out_vld_nxt;

  always_comb begin
    w_push     = self_xfer(in_link.valid, r_stop);
    // Output register accepts a new word when empty or being drained this cycle.
    w_load     = !r_out_vld || !out_link.stop;
    w_has_data = (r_count != '0);
    w_arr_rd   = w_load && w_has_data;
    w_bypass   = w_load && !w_has_data && w_push;
    w_arr_wr   = w_push && !w_bypass;
    w_count_nxt  = r_count + (w_arr_wr ? CntOne : '0) - (w_arr_rd ? CntOne : '0);
    w_rd_ptr_nxt = r_rd_ptr + (w_arr_rd ? PtrOne : '0);
    w_out_vld_nxt = w_load ? (w_has_data || w_push) : r_out_vld;
  end

  self_link_fifo_ram #(
    .DataWidth (DataWidth),
    .AddrWidth (FifoIndexSize)
  ) u_ram (
    .clk           (clk),
    .srst          (srst),
    .i_wr_en       (w_arr_wr),
    .i_wr_addr     (r_wr_ptr),
    .i_wr_dat      (in_link.data),
    .i_rd_addr_nxt (w_rd_ptr_nxt),
    .o_rd_dat      (w_head_dat)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_stop    <= 1'b1;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
    end else begin
      if (w_arr_wr) r_wr_ptr <= r_wr_ptr + PtrOne;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_stop    <= (w_count_nxt >= StopLvl);
      r_out_vld <= w_out_vld_nxt;
      if (w_arr_rd) r_out_dat <= w_head_dat;
      else if (w_bypass) r_out_dat <= in_link.data;
    end
  end

  assign in_link.stop   = r_stop;
  assign out_link.valid = r_out_vld;
  assign out_link.data  = r_out_dat;

`ifdef SELF_LINK_FIFO_LEVEL_EN
  localparam logic [FifoIndexSize+1:0] FillOne = 1;
  localparam logic [FifoIndexSize:0]   CntFull = (FifoIndexSize+1)'(FifoSize);

  logic [FifoIndexSize+1:0] r_fill;
  logic                     r_ovf;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_fill <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_fill <= {1'b0, w_count_nxt} + (w_out_vld_nxt ? FillOne : '0);
      if (w_push && (r_count == CntFull)) r_ovf <= 1'b1;
    end
  end

  assign fillLevel   = r_fill;
  assign overflowErr = r_ovf;
`endif
endmodule

// File: tb/tb_self_link_fifo_buffer_p.sv
// Scoreboard bench for self_link_fifo_buffer_p (main instance StopLevel=16, second StopLevel=12).
// Latency: n/a.
// Backpressure: randomised on both sides in the soak phase.
module tb_self_link_fifo_buffer_p;
  localparam int DW = 8;
  localparam int FS = 16;
  localparam int FI = 4;
  localparam int SL = 16;
  localparam int SL2 = 12;

  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  self_link_fifo_buffer_p_if #(.DataWidth(DW)) in1 ();
  self_link_fifo_buffer_p_if #(.DataWidth(DW)) out1 ();
  self_link_fifo_buffer_p_if #(.DataWidth(DW)) in2 ();
  self_link_fifo_buffer_p_if #(.DataWidth(DW)) out2 ();

`ifdef SELF_LINK_FIFO_LEVEL_EN
  logic [FI+1:0] fill1, fill2;
  logic          ovf1, ovf2;
`endif

  self_link_fifo_buffer_p #(.DataWidth(DW), .FifoSize(FS), .FifoIndexSize(FI), .StopLevel(SL)) dut (
    .clk (clk), .srst (srst), .in_link (in1), .out_link (out1)
`ifdef SELF_LINK_FIFO_LEVEL_EN
    , .fillLevel (fill1), .overflowErr (ovf1)
`endif
  );

  self_link_fifo_buffer_p #(.DataWidth(DW), .FifoSize(FS), .FifoIndexSize(FI), .StopLevel(SL2)) dut2 (
    .clk (clk), .srst (srst), .in_link (in2), .out_link (out2)
`ifdef SELF_LINK_FIFO_LEVEL_EN
    , .fillLevel (fill2), .overflowErr (ovf2)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: words accepted and not yet delivered, in order.
  logic [DW-1:0] sb_q[$];
  bit was_rst = 1'b1;

  // Monitor: at each falling edge, the state reflects the last rising edge and the
  // signals show what the coming rising edge will transfer.
  always @(negedge clk) begin
    int occ;
    int arr;
    logic [DW-1:0] exp_d;
    occ = sb_q.size();
    arr = (occ > 0) ? occ - 1 : 0;
    if (was_rst) begin
      chk("rst_out_valid", out1.valid, 0);
      chk("rst_out_data", out1.data, 0);
      chk("rst_in_stop", in1.stop, 1);
    end else begin
      chk("out_valid_vs_model", out1.valid, (occ > 0) ? 1 : 0);
      chk("in_stop_vs_model", in1.stop, (arr >= SL) ? 1 : 0);
`ifdef SELF_LINK_FIFO_LEVEL_EN
      chk("fill_level", fill1, occ);
      chk("overflow_err", ovf1, 0);
`endif
    end
    if (srst) begin
      sb_q.delete();
      was_rst = 1'b1;
    end else begin
      was_rst = 1'b0;
      if (out1.valid && !out1.stop) begin
        if (sb_q.size() == 0) begin
          chk("pop_on_empty_model", 1, 0);
        end else begin
          exp_d = sb_q.pop_front();
          chk("out_data_order", out1.data, exp_d);
        end
      end
      if (in1.valid && !in1.stop) sb_q.push_back(in1.data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int pops;
    int cycles;
    bit seen;
    in1.valid = 1'b0; in1.data = '0; out1.stop = 1'b0;
    in2.valid = 1'b0; in2.data = '0; out2.stop = 1'b0;
    srst = 1'b1;
    repeat (3) cyc();
    chk("reset_stop_held", in1.stop, 1);
    chk("reset_out_valid", out1.valid, 0);
    srst = 1'b0;
    cyc();
    chk("stop_drops_after_reset", in1.stop, 0);

    // Empty bypass: 0xA5 pushed at N appears at N+1.
    in1.valid = 1'b1; in1.data = 8'hA5;
    @(negedge clk);
    chk("bypass_accept", (in1.valid && !in1.stop) ? 1 : 0, 1);
    cyc();
    in1.valid = 1'b0; in1.data = 8'h00;
    @(negedge clk);
    chk("bypass_valid", out1.valid, 1);
    chk("bypass_data", out1.data, 8'hA5);
    cyc();
    repeat (2) cyc();

    // Fill with consumer stalled: 16 array slots + output register.
    out1.stop = 1'b1;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      in1.valid = 1'b1; in1.data = acc[DW-1:0];
      @(negedge clk);
      if (in1.valid && !in1.stop) acc++;
      cyc();
    end
    chk("fill_words_taken", acc, 17);
    chk("fill_stop_high", in1.stop, 1);
    in1.valid = 1'b0;
    out1.stop = 1'b0;
    repeat (25) cyc();

    // Reset mid-stream with 5 words queued.
    out1.stop = 1'b1;
    acc = 0;
    for (int i = 0; i < 20 && acc < 5; i++) begin
      in1.valid = 1'b1; in1.data = 8'h30 + acc[DW-1:0];
      @(negedge clk);
      if (in1.valid && !in1.stop) acc++;
      cyc();
    end
    chk("midrst_queued", acc, 5);
    srst = 1'b1;
    cyc();
    chk("midrst_out_valid", out1.valid, 0);
    chk("midrst_in_stop", in1.stop, 1);
    srst = 1'b0;
    out1.stop = 1'b0;
    in1.valid = 1'b1; in1.data = 8'h77;
    acc = 0;
    for (int i = 0; i < 5 && acc == 0; i++) begin
      @(negedge clk);
      if (in1.valid && !in1.stop) acc++;
      cyc();
    end
    in1.valid = 1'b0;
    chk("midrst_push_taken", acc, 1);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (out1.valid) begin
        seen = 1'b1;
        chk("midrst_first_word", out1.data, 8'h77);
      end
      cyc();
    end
    chk("midrst_output_seen", seen, 1);
    repeat (3) cyc();

    // Throughput: 100 words back to back, both sides free.
    acc = 0; pops = 0;
    for (int i = 0; i < 101; i++) begin
      in1.valid = (i < 100); in1.data = i[DW-1:0];
      @(negedge clk);
      if (in1.valid && !in1.stop) acc++;
      if (out1.valid && !out1.stop) pops++;
      cyc();
    end
    in1.valid = 1'b0;
    chk("tput_pushes", acc, 100);
    chk("tput_pops", pops, 100);
    repeat (3) cyc();

    // Early stop on the StopLevel=12 instance.
    out2.stop = 1'b1;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      in2.valid = 1'b1; in2.data = $urandom_range(0, 255);
      @(negedge clk);
      if (in2.valid && !in2.stop) acc++;
      cyc();
    end
    chk("early_stop_taken", acc, SL2 + 1);
    chk("early_stop_high", in2.stop, 1);
`ifdef SELF_LINK_FIFO_LEVEL_EN
    chk("early_stop_fill", fill2, SL2 + 1);
    chk("early_stop_ovf", ovf2, 0);
`endif
    in2.valid = 1'b0;

    // Random soak: 10k accepted words, 50% valid, 50% downstream stop.
    acc = 0; cycles = 0;
    while (acc < 10000 && cycles < 40000) begin
      in1.valid = $urandom_range(0, 1);
      in1.data  = $urandom_range(0, 255);
      out1.stop = $urandom_range(0, 1);
      @(negedge clk);
      if (in1.valid && !in1.stop) acc++;
      cyc();
      cycles++;
    end
    chk("soak_words_accepted", acc, 10000);
    in1.valid = 1'b0;
    out1.stop = 1'b0;
    repeat (30) cyc();
    chk("soak_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
